// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two writeback requester channels, the register-file write
//   port and the arbiter status signals.
//
//   master : requester/environment side (drives req*_valid/addr/data,
//            observes readys, register-file write port and status)
//   slave  : arbiter side (the regfile_write_arbiter module)
//
//   Signals
//     req0_valid/addr/data/ready : requester 0 (ALU writeback)
//     req1_valid/addr/data/ready : requester 1 (load writeback)
//     rf_regWrite                : register file write enable
//     rf_addrDestination         : register file write address
//     rf_writeData               : register file write data
//     grant_id                   : requester owning the current rf_* write
//     busy                       : clear sequence in progress
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;

  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;

  logic        rf_regWrite;
  logic [4:0]  rf_addrDestination;
  logic [31:0] rf_writeData;
  logic        grant_id;
  logic        busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_regWrite, rf_addrDestination, rf_writeData,
    input  grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_regWrite, rf_addrDestination, rf_writeData,
    output grant_id, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Arbitrates two writeback requesters (ALU = 0, load = 1) onto a single
//   register-file write port with round-robin priority. Accepted writes
//   appear on the rf_* outputs exactly one cycle after the handshake.
//   Writes to register 0 are accepted but suppressed.
//
//   Optional power-on clear (macro REGARB_CLEAR_EN): after reset the block
//   writes CLEAR_VALUE to registers 1..31 on consecutive cycles, holding
//   busy high and refusing requests until done. Without the macro the
//   block starts arbitrating on the first active cycle and busy is 0.
//
//   Parameters
//     CLEAR_VALUE : word written to every register during the clear sequence
//     RR_INIT     : requester favoured first after reset
//
//   Ports
//     clk : clock, all state updates on rising edge
//     rst : asynchronous active-low reset
//     bus : regfile_write_arbiter_if.slave (requesters, rf write port, status)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000,
  parameter logic        RR_INIT     = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_ARB   = 1'b1
  } state_e;

`ifdef REGARB_CLEAR_EN
  localparam state_e RESET_STATE = S_CLEAR;
`else
  localparam state_e RESET_STATE = S_ARB;
`endif

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        gid_q, gid_d;

`ifdef REGARB_CLEAR_EN
  logic [4:0]  cnt_q, cnt_d;
`endif

  logic        ready0, ready1;
  logic        pick0, pick1;

  // Request selection: requester 1 wins when it is the only one asking or
  // when both ask and the pointer favours it.
  always_comb begin
    pick1 = bus.req1_valid && (!bus.req0_valid || rr_q);
    pick0 = bus.req0_valid && !pick1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
`ifdef REGARB_CLEAR_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      S_CLEAR: begin
`ifdef REGARB_CLEAR_EN
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = CLEAR_VALUE;
        if (cnt_q == 5'd31) begin
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
`else
        state_d = S_ARB;
`endif
      end

      S_ARB: begin
        ready0 = pick0;
        ready1 = pick1;
        // A handshake always captures address/data/owner so the rf_* fields
        // reflect the last accepted request; the enable is suppressed for
        // register 0.
        if (pick0 || pick1) begin
          rr_d   = pick0;
          gid_d  = pick1;
          addr_d = pick1 ? bus.req1_addr : bus.req0_addr;
          data_d = pick1 ? bus.req1_data : bus.req0_data;
          we_d   = (addr_d != 5'd0);
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_STATE;
      rr_q    <= RR_INIT;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

`ifdef REGARB_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 5'd1;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.req0_ready         = ready0;
  assign bus.req1_ready         = ready1;
  assign bus.rf_regWrite        = we_q;
  assign bus.rf_addrDestination = addr_q;
  assign bus.rf_writeData       = data_q;
  assign bus.grant_id           = gid_q;
  assign bus.busy               = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam logic [31:0] CV  = 32'hA5A5_0F0F;
  localparam logic        RRI = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .CLEAR_VALUE(CV),
    .RR_INIT    (RRI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_clearing;
  int          m_clear_next;
  bit          m_ptr;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_gid;
  bit          m_known;
  bit          m_hs0, m_hs1;
  bit          mr0, mr1;
  bit          cr0, cr1;

  task automatic model_reset();
`ifdef REGARB_CLEAR_EN
    m_clearing = 1'b1;
`else
    m_clearing = 1'b0;
`endif
    m_clear_next = 1;
    m_ptr   = RRI;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_gid   = 1'b0;
    m_known = 1'b1;
    m_hs0   = 1'b0;
    m_hs1   = 1'b0;
  endtask

  function automatic void exp_ready(output bit r0, output bit r1);
    if (m_clearing) begin
      r0 = 1'b0; r1 = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      r0 = (m_ptr == 1'b0); r1 = (m_ptr == 1'b1);
    end else begin
      r0 = bus.req0_valid; r1 = bus.req1_valid;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      exp_ready(mr0, mr1);
      m_hs0 = bus.req0_valid && mr0;
      m_hs1 = bus.req1_valid && mr1;
      if (m_clearing) begin
        m_we   = 1'b1;
        m_addr = m_clear_next[4:0];
        m_data = CV;
        if (m_clear_next == 31) m_clearing = 1'b0;
        else m_clear_next++;
      end else if (m_hs0 || m_hs1) begin
        m_ptr = m_hs0 ? 1'b1 : 1'b0;
        if ((m_hs1 ? bus.req1_addr : bus.req0_addr) != 5'd0) begin
          m_we    = 1'b1;
          m_addr  = m_hs1 ? bus.req1_addr : bus.req0_addr;
          m_data  = m_hs1 ? bus.req1_data : bus.req0_data;
          m_gid   = m_hs1;
          m_known = 1'b1;
        end else begin
          m_we    = 1'b0;
          m_known = 1'b0;
        end
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_ready(cr0, cr1);
    chk("busy", {31'd0, bus.busy}, {31'd0, m_clearing});
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, cr0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, cr1});
    chk("rf_regWrite", {31'd0, bus.rf_regWrite}, {31'd0, m_we});
    if (m_known) begin
      chk("rf_addr", {27'd0, bus.rf_addrDestination}, {27'd0, m_addr});
      chk("rf_data", bus.rf_writeData, m_data);
      chk("grant_id", {31'd0, bus.grant_id}, {31'd0, m_gid});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

`ifdef REGARB_CLEAR_EN
  // Called right after reset release (at posedge+3); follows one full clear.
  task automatic run_clear_check(input string tag);
    int nb;
    int nexta;
    nb = 0;
    nexta = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nb++;
      if (bus.rf_regWrite) begin
        chk({tag, "_addr"}, {27'd0, bus.rf_addrDestination}, nexta);
        chk({tag, "_data"}, bus.rf_writeData, CV);
        nexta++;
      end
    end
    chk({tag, "_busy_cycles"}, nb, 31);
    chk({tag, "_writes_before_last"}, nexta, 31);
    chk({tag, "_last_we"}, {31'd0, bus.rf_regWrite}, 32'd1);
    chk({tag, "_last_addr"}, {27'd0, bus.rf_addrDestination}, 32'd31);
  endtask
`endif

  initial begin
    model_reset();
    drive(0, '0, '0, 0, '0, '0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, bus.rf_regWrite}, 32'd0);
    chk("rst_addr", {27'd0, bus.rf_addrDestination}, 32'd0);
    chk("rst_data", bus.rf_writeData, 32'd0);
    chk("rst_gid", {31'd0, bus.grant_id}, 32'd0);

`ifdef REGARB_CLEAR_EN
    @(posedge clk); #3;
    drive(1, 5'd8, 32'h1111_2222, 0, '0, '0);
    rst = 1'b1;
    run_clear_check("clr1");
    chk("clr1_first_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #2;
    drive(0, '0, '0, 0, '0, '0);

    // Abort the clear midway: counter is 17 after 16 active edges.
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #3; rst = 1'b1;
    repeat (16) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("midclr_rst_we", {31'd0, bus.rf_regWrite}, 32'd0);
    @(posedge clk); #3; rst = 1'b1;
    run_clear_check("clr2");
`else
    // Request waiting on the very first active cycle.
    drive(0, '0, '0, 1, 5'd31, 32'hCAFE_0031);
    @(posedge clk); #3; rst = 1'b1;
    @(negedge clk);
    chk("first_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("first_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #2;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    chk("first_we", {31'd0, bus.rf_regWrite}, 32'd1);
    chk("first_addr", {27'd0, bus.rf_addrDestination}, 32'd31);
    chk("first_data", bus.rf_writeData, 32'hCAFE_0031);
    chk("first_gid", {31'd0, bus.grant_id}, 32'd1);
`endif

    // Single requester 0.
    @(posedge clk); #2;
    drive(1, 5'd8, 32'hDEAD_BEEF, 0, '0, '0);
    @(negedge clk);
    chk("r0only_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("r0only_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #2;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    chk("r0only_we", {31'd0, bus.rf_regWrite}, 32'd1);
    chk("r0only_addr", {27'd0, bus.rf_addrDestination}, 32'd8);
    chk("r0only_data", bus.rf_writeData, 32'hDEAD_BEEF);
    chk("r0only_gid", {31'd0, bus.grant_id}, 32'd0);
    @(negedge clk);
    chk("hold_we", {31'd0, bus.rf_regWrite}, 32'd0);
    chk("hold_addr", {27'd0, bus.rf_addrDestination}, 32'd8);
    chk("hold_data", bus.rf_writeData, 32'hDEAD_BEEF);

    // Requester 1 writing register 0: accepted, no write, pointer to 0.
    @(posedge clk); #2;
    drive(0, '0, '0, 1, 5'd0, 32'h1234_5678);
    @(negedge clk);
    chk("a0_ready1", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #2;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    chk("a0_we", {31'd0, bus.rf_regWrite}, 32'd0);

    // Both requesters for four cycles: 0,1,0,1.
    @(posedge clk); #2;
    drive(1, 5'd3, 32'h0000_0003, 1, 5'd4, 32'h0000_0004);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) chk("rr_ready0", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("rr_we", {31'd0, bus.rf_regWrite}, 32'd1);
        chk("rr_addr", {27'd0, bus.rf_addrDestination}, ((k - 1) % 2 == 0) ? 32'd3 : 32'd4);
        chk("rr_gid", {31'd0, bus.grant_id}, ((k - 1) % 2 == 0) ? 32'd0 : 32'd1);
      end
      @(posedge clk); #2;
      if (k == 3) drive(0, '0, '0, 0, '0, '0);
    end

    // Randomized traffic with occasional resets; requests are held until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (!bus.req0_valid || m_hs0) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || m_hs1) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bus.req1_data  = $urandom;
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 32'h0000_0000, the word written to every register during the clear sequence.
REQ-002 SHALL have parameter RR_INIT, default 1'b0, the requester favoured first after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  5  requester 0 destination register.
REQ-007 req0_data  input  32  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid / req1_addr / req1_data / req1_ready SHALL mirror REQ-005..008 for requester 1 (load writeback).
REQ-010 rf_regWrite  output  1  write enable to the register file.
REQ-011 rf_addrDestination  output  5  register file write address.
REQ-012 rf_writeData  output  32  register file write data.
REQ-013 grant_id  output  1  requester that owns the current rf_* write.
REQ-014 busy  output  1  clear sequence in progress; no requests accepted.

Function
REQ-015 SHALL implement FSM states CLEAR and ARB; CLEAR -> ARB when clear counter reaches 31; ARB has no exit except reset.
REQ-016 In CLEAR: counter starts at 1, increments by 1 per cycle; each cycle drives rf_regWrite=1, rf_addrDestination=counter, rf_writeData=CLEAR_VALUE (registered, one cycle after counter value); exactly 31 writes, addresses 1..31 in order; register 0 never written.
REQ-017 busy SHALL be 1 exactly while state==CLEAR; req0_ready and req1_ready SHALL be 0 while busy.
REQ-018 In ARB, readys are combinational: only one valid -> that requester ready; both valid -> requester indicated by rr pointer ready, other 0; none valid -> both 0.
REQ-019 A handshake is valid && ready in the same cycle; at most one handshake per cycle.
REQ-020 After a handshake by requester i, rr pointer SHALL become 1-i on the next edge; pointer unchanged in cycles without handshake.
REQ-021 Latency: handshake in cycle N -> rf_regWrite=1 with the captured addr/data and grant_id=i in cycle N+1 only.
REQ-022 Handshake with addr 5'd0 SHALL be accepted (ready as REQ-018) but produce rf_regWrite=0 in cycle N+1; pointer still updates.
REQ-023 No handshake in cycle N -> rf_regWrite=0 in cycle N+1; rf_addrDestination, rf_writeData, grant_id hold previous values.
REQ-024 Back-to-back handshakes SHALL produce writes on consecutive cycles with no bubble; a sustained two-requester load alternates 0,1,0,1...
REQ-025 Requesters SHALL hold valid/addr/data stable until ready; arbiter does not buffer unaccepted requests.

Reset
REQ-026 On rst low, asynchronously: rf_regWrite=0, rf_addrDestination=0, rf_writeData=0, grant_id=0, rr pointer=RR_INIT, clear counter=1.
REQ-027 State after reset SHALL be CLEAR when REGARB_CLEAR_EN is defined, ARB otherwise; busy follows.
REQ-028 Reset asserted mid-clear or mid-transfer SHALL abort it; clear restarts from address 1 after release; an in-flight accepted write is dropped.
REQ-029 First rising clk after rst deasserts SHALL be the first active cycle.

Configuration
REQ-030 Macro REGARB_CLEAR_EN: defined -> CLEAR state, counter and REQ-016/017 clear behaviour compiled in; undefined -> CLEAR logic absent, FSM reset state ARB, busy tied 0, requests accepted from the first active cycle.

Verification
REQ-031 REGARB_CLEAR_EN defined, release rst, drive req0_valid=1 throughout -> 31 writes CLEAR_VALUE to addrs 1..31 on consecutive cycles, busy=1 for 31 cycles, req0_ready first 1 on cycle 32.
REQ-032 ARB, req0 only: addr=5'd8, data=32'hDEAD_BEEF -> req0_ready=1 same cycle; next cycle rf_regWrite=1, addr=8, data=32'hDEAD_BEEF, grant_id=0.
REQ-033 ARB, RR_INIT=0, both valid for 4 cycles (req0 addr 3, req1 addr 4) -> grants 0,1,0,1; rf_addrDestination 3,4,3,4 on consecutive cycles.
REQ-034 ARB, req1 addr=5'd0, data=32'h1234_5678 -> req1_ready=1, rf_regWrite=0 next cycle, pointer moves to 0.
REQ-035 Assert rst low at clear counter=17, release -> clear restarts at addr 1, full 31 writes again; rf_regWrite=0 during reset.
REQ-036 REGARB_CLEAR_EN undefined, req1 valid addr 31 on first active cycle -> req1_ready=1, busy=0, write to 31 the next cycle.
